// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//   - CLKS_PER_BIT_DEF : default clock cycles per bit (230400 baud at 100 MHz)
//   - uart_state_e     : one-hot frame FSM state encodings
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

  // One-hot encodings: exactly one bit set per state.
  typedef enum logic [4:0] {
    QINI   = 5'b00001,
    QSTART = 5'b00010,
    QTX    = 5'b00100,
    QSTOP  = 5'b01000,
    QDONE  = 5'b10000
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps; the
// terminal count produces a one-cycle tick marking the end of a bit.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset
//   enable_i : advance the counter; when low the count holds
//   clear_i  : force the count back to zero (takes priority over enable)
//   tick_o   : high in the enabled cycle holding the terminal count
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  // Guard against a zero-width counter when CLKS_PER_BIT is 1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && !clear_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (tick_o)   cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1-style frame (start bit, DATA_WIDTH data bits LSB
// first, one stop bit) on a registered, idle-high serial line.
//   CLK100MHZ : clock, rising edge
//   reset     : synchronous active-low reset
//   isTx      : enable; when low the FSM, baud counter, index and TXD hold
//   start     : send request, only honoured when idle and enabled
//   data_in   : payload, captured when start is accepted
//   TXD       : serial output
//   busy      : high in every state except idle
//   done      : one-cycle pulse in the enabled completion cycle
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  isTx,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  TXD,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  txd_q, txd_d;
  logic                  bit_tick;
  logic                  cnt_clr;

  // Holding the counter at zero outside the bit-timed states means the
  // start bit always begins with a fresh count.
  assign cnt_clr = (state_q == QINI) || (state_q == QDONE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (CLK100MHZ),
    .rst_ni  (reset),
    .enable_i(isTx),
    .clear_i (cnt_clr),
    .tick_o  (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    if (isTx) begin
      case (state_q)
        QINI: begin
          txd_d = 1'b1;
          if (start) begin
            sh_d    = data_in;
            idx_d   = '0;
            txd_d   = 1'b0;
            state_d = QSTART;
          end
        end
        QSTART: begin
          if (bit_tick) begin
            txd_d   = sh_q[0];
            state_d = QTX;
          end
        end
        QTX: begin
          if (bit_tick) begin
            if (idx_q == LAST) begin
              txd_d   = 1'b1;
              state_d = QSTOP;
            end else begin
              // Shift first so the next bit is always at position 0.
              idx_d = idx_q + IW'(1);
              sh_d  = sh_q >> 1;
              txd_d = sh_d[0];
            end
          end
        end
        QSTOP: begin
          if (bit_tick) begin
            txd_d   = 1'b1;
            state_d = QDONE;
          end
        end
        QDONE: begin
          txd_d   = 1'b1;
          state_d = QINI;
        end
        default: begin
          txd_d   = 1'b1;
          state_d = QINI;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      state_q <= QINI;
      sh_q    <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

  assign TXD  = txd_q;
  assign busy = (state_q != QINI);
  // Gated by isTx so a stalled completion cycle never stretches the pulse.
  assign done = (state_q == QDONE) && isTx;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  localparam int DW  = 8;
  localparam int CPB = 434;
  localparam int FB  = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset, isTx, start;
  logic [7:0] data_in;
  logic       TXD, busy, done;

  always #5 clk = ~clk;

  uart_transmitter #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .CLK100MHZ(clk), .reset(reset), .isTx(isTx), .start(start),
    .data_in(data_in), .TXD(TXD), .busy(busy), .done(done)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_pushed = 0;
  int         n_rx = 0;
  int         rst_evt = 0;
  logic [7:0] sbq[$];

  typedef struct {
    logic [7:0] d;
    logic [9:0] pat;
    int         done_at;
    int         stall_at;
    int         stall_len;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count reset edges so the monitor can drop a frame cut short by reset.
  always @(posedge clk) if (!reset) rst_evt <= rst_evt + 1;

  // Receiver model: mid-bit sampling, compared against the scoreboard.
  initial begin
    int         snap, t;
    logic [8:0] b;
    logic [7:0] mexp;
    bit         ok;
    forever begin
      @(negedge clk);
      if (TXD === 1'b0) begin
        snap = rst_evt; t = 0; ok = 1; b = '0;
        while (ok && t < CPB/2 + 9*CPB) begin
          @(negedge clk);
          t++;
          if (rst_evt != snap) ok = 0;
          else if (t > CPB/2 && ((t - CPB/2) % CPB) == 0) b[(t - CPB/2)/CPB - 1] = TXD;
        end
        if (ok) begin
          n_rx++;
          mexp = 'x;
          if (sbq.size() > 0) mexp = sbq.pop_front();
          chk("sb_byte", {24'b0, b[7:0]}, {24'b0, mexp});
          chk("sb_stop", {31'b0, b[8]}, 32'd1);
        end
      end
    end
  end

  // Drives one frame and checks TXD/busy/done every cycle against the
  // position p (enabled edges since acceptance). Called at a negedge with
  // the DUT idle; returns in the first idle cycle after the frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [9:0] pat,
                           input int done_at, input int stall_at, input int stall_len,
                           input int inj_at, input int abort_at, input bit push);
    int   p, k, dis, done_k, ndone, e_txd, e_busy, e_done, bi, run_len, bad;
    int   runs[$];
    logic exp_txd, last_txd;
    bit   stalled;
    data_in = d; start = 1'b1; isTx = 1'b1;
    if (push) begin sbq.push_back(d); n_pushed++; end
    @(negedge clk);
    start = 1'b0; data_in = ~d;
    p = 0; k = 1; dis = 0; stalled = 0; done_k = -1; ndone = 0;
    e_txd = 0; e_busy = 0; e_done = 0; run_len = 0; last_txd = 1'b0;
    while (p <= FB) begin
      if (k > FB + stall_len + 20) begin
        chk({tag, "_timeout"}, p, FB + 1);
        break;
      end
      bi = p / CPB;
      exp_txd = (bi < 10) ? pat[bi] : 1'b1;
      if (TXD !== exp_txd) e_txd++;
      if (busy !== 1'b1) e_busy++;
      if (done !== (p == FB)) e_done++;
      if (done === 1'b1) begin ndone++; if (done_k < 0) done_k = k; end
      if (p < FB) begin
        if (TXD === last_txd) run_len++;
        else begin runs.push_back(run_len); run_len = 1; last_txd = TXD; end
      end
      if (abort_at >= 0 && p == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk({tag, "_txd_after_rst"}, {31'b0, TXD}, 32'd1);
        chk({tag, "_busy_after_rst"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done_after_rst"}, {31'b0, done}, 32'd0);
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (TXD !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk({tag, "_no_glitch"}, bad, 0);
        chk({tag, "_txd_before_rst"}, e_txd, 0);
        return;
      end
      start = (inj_at >= 0 && p >= inj_at && p < inj_at + 3);
      if (start) data_in = 8'h0F;
      if (stall_len > 0 && !stalled && p == stall_at) begin stalled = 1; dis = stall_len; end
      if (dis > 0) begin isTx = 1'b0; dis--; end
      else isTx = 1'b1;
      @(negedge clk);
      if (isTx) p++;
      k++;
    end
    start = 1'b0; isTx = 1'b1;
    chk({tag, "_idle"}, {29'b0, TXD, busy, done}, 32'b100);
    chk({tag, "_txd_seq"}, e_txd, 0);
    chk({tag, "_busy"}, e_busy, 0);
    chk({tag, "_done_level"}, e_done, 0);
    chk({tag, "_done_cycle"}, done_k, done_at);
    chk({tag, "_done_count"}, ndone, 1);
    if (stall_len > 0 && runs.size() > 3) begin
      chk({tag, "_bit1_len"}, runs[1], CPB);
      chk({tag, "_bit2_len"}, runs[2], CPB + stall_len);
      chk({tag, "_bit3_len"}, runs[3], CPB);
    end
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    logic [7:0] d;
    tbl[0] = '{8'hA5, 10'b1101001010, 4341, -1, 0};
    tbl[1] = '{8'h55, 10'b1010101010, 4441, 2*CPB + 100, 100};
    tbl[2] = '{8'h3C, 10'b1001111000, 4341, -1, 0};
    tbl[3] = '{8'hC3, 10'b1110000110, 4341, -1, 0};

    // Reset holds idle regardless of isTx and a held start.
    reset = 1'b0; isTx = 1'b0; start = 1'b1; data_in = 8'h81;
    repeat (3) @(negedge clk);
    chk("rst_state", {29'b0, TXD, busy, done}, 32'b100);
    isTx = 1'b1;
    @(negedge clk);
    chk("rst_start_held", {29'b0, TXD, busy, done}, 32'b100);
    reset = 1'b1;
    @(negedge clk);
    chk("first_edge_accept", {30'b0, TXD, busy}, 32'b01);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_abort_early", {29'b0, TXD, busy, done}, 32'b100);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      run_frame("tbl", tbl[i].d, tbl[i].pat, tbl[i].done_at, tbl[i].stall_at, tbl[i].stall_len, -1, -1, 1);

    // Reset during bit 3 of 8'hFF, then a clean 8'h3C frame.
    run_frame("abort", 8'hFF, 10'b1111111110, 0, -1, 0, -1, 3*CPB + 50, 0);
    run_frame("post_abort", 8'h3C, 10'b1001111000, 4341, -1, 0, -1, -1, 1);

    // start with 8'h0F while busy must not disturb or re-trigger.
    run_frame("busy_start", 8'h81, 10'b1100000010, 4341, -1, 0, 4*CPB, -1, 1);
    bad = 0;
    repeat (CPB) begin
      @(negedge clk);
      if (busy !== 1'b0 || TXD !== 1'b1 || done !== 1'b0) bad++;
    end
    chk("no_second_frame", bad, 0);

    // Back-to-back: second start in the cycle after done.
    run_frame("b2b0", 8'h00, 10'b1000000000, 4341, -1, 0, -1, -1, 1);
    run_frame("b2b1", 8'hFF, 10'b1111111110, 4341, -1, 0, -1, -1, 1);

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      run_frame("rand", d, {1'b1, d, 1'b0}, 4341, -1, 0, -1, -1, 1);
    end

    repeat (10) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("rx_count", n_rx, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per bit (230400 baud at 100 MHz).
REQ-003 SHALL have port CLK100MHZ  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-low reset.
REQ-005 SHALL have port isTx  input  1: enable; when low, the FSM and baud counter hold their state.
REQ-006 SHALL have port start  input  1: request to send data_in; sampled only in Qini with isTx high.
REQ-007 SHALL have port data_in  input  DATA_WIDTH: payload, captured into a shift register on accepted start.
REQ-008 SHALL have port TXD  output  1: serial line, idle high.
REQ-009 SHALL have port busy  output  1: high in every state except Qini.
REQ-010 SHALL have port done  output  1: one-cycle pulse when the frame is complete.

Function
REQ-011 SHALL use a one-hot FSM with states Qini, Qstart, Qtx, Qstop and Qdone.
REQ-012 Qini: TXD=1; start=1 with isTx=1 SHALL capture data_in, clear the bit index and baud counter, and go to Qstart.
REQ-013 Qstart SHALL drive TXD=0 for CLKS_PER_BIT cycles, then go to Qtx.
REQ-014 Qtx SHALL drive bits LSB first, each for CLKS_PER_BIT cycles; after bit DATA_WIDTH-1 it SHALL go to Qstop.
REQ-015 Qstop SHALL drive TXD=1 for CLKS_PER_BIT cycles, then go to Qdone.
REQ-016 Qdone SHALL last one cycle with done=1, TXD=1, busy=1, then return to Qini.
REQ-017 Timing SHALL be as follows: with start accepted at edge N, the TXD start bit covers cycles N+1..N+CLKS_PER_BIT, and done is high in cycle N+(DATA_WIDTH+2)*CLKS_PER_BIT+1.
REQ-018 The earliest next start SHALL be accepted in the cycle after done.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; its terminal count generates a one-cycle bit tick.
REQ-020 The counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-021 Bit index width SHALL be $clog2(DATA_WIDTH)+1; it SHALL never exceed DATA_WIDTH-1 while indexing.
REQ-022 start SHALL be ignored while busy=1: no recapture and no frame disturbance.
REQ-023 data_in changes after capture SHALL NOT affect the frame in flight.
REQ-024 When isTx=0, state, counter, index and TXD SHALL hold, stretching the current bit by the number of disabled cycles.
REQ-025 A done pulse SHALL NOT be extended by isTx=0; done SHALL be high for exactly one enabled Qdone cycle.
REQ-026 TXD SHALL be registered, with no combinational path from inputs.

Reset
REQ-027 reset=0 at a clock edge SHALL force Qini, TXD=1, busy=0, done=0, counter=0, index=0 and shift register=0, regardless of isTx.
REQ-028 Reset mid-frame SHALL abort the frame; TXD SHALL be 1 from the next cycle on, with no glitch to 0 afterwards.
REQ-029 A start held high during reset SHALL NOT be accepted until the first edge with reset=1.

Structure
REQ-030 State encodings (one-hot localparams) and the default CLKS_PER_BIT SHALL live in a shared uart package/include, shared with the receiver.
REQ-031 The baud tick SHALL come from one sub-module, uart_baud_tick (enable, clear, tick), instantiated once.
REQ-032 The shift register and FSM SHALL stay in uart_transmitter; there SHALL be no other sub-modules.

Verification
REQ-033 start with data_in=8'hA5 -> TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit 434 cycles; done at N+4341.
REQ-034 Assert reset=0 in bit 3 of an 8'hFF frame -> next cycle TXD=1, busy=0; a following 8'h3C frame is correct.
REQ-035 start with 8'h0F while busy, mid 8'h81 frame -> 8'h81 sent intact; no second frame; single done.
REQ-036 Drop isTx for 100 cycles inside bit 2 of 8'h55 -> bit 2 lasts 534 cycles; all other bits 434; done is delayed 100 cycles.
REQ-037 Back-to-back 8'h00 then 8'hFF, start asserted the cycle after done -> two contiguous frames and two done pulses.
REQ-038 Loopback TXD into the team UART receiver, random 256 bytes -> every byte is received equal to the byte sent.
